// File: rtl/clk_seq_ctrl.sv
// rtl/clk_seq_ctrl.sv - ordered power-up/power-down sequencer for a bank of clock generator enables
// Channels rise lowest-first and fall highest-first, one change per step, gap_l idle cycles between steps.
module clk_seq_ctrl #(
   parameter int N_CLK = 4,
   parameter int GAP_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_stop,
   input  logic [GAP_W-1:0] i_gap,
   input  logic [N_CLK-1:0] i_mask,
   output logic [N_CLK-1:0] o_en_out,
   output logic             o_busy,
   output logic             o_running,
   output logic             o_done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_UP   = 2'd1,
      S_RUN  = 2'd2,
      S_DOWN = 2'd3
   } state_t;

   localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

   state_t           r_state;
   logic [GAP_W-1:0] r_gap_l;
   logic [N_CLK-1:0] r_mask_l;
   logic [GAP_W-1:0] r_cnt;
   logic [N_CLK-1:0] r_en_out;
   logic             r_busy;
   logic             r_running;
   logic             r_done;

   logic [N_CLK-1:0] w_first_bit;
   logic [N_CLK-1:0] w_up_pend;
   logic [N_CLK-1:0] w_up_bit;
   logic [N_CLK-1:0] w_dn_bit;

   function automatic logic [N_CLK-1:0] f_lowest(input logic [N_CLK-1:0] v);
      logic [N_CLK-1:0] r;
      r = '0;
      for (int i = N_CLK - 1; i >= 0; i--) begin
         if (v[i]) begin
            r    = '0;
            r[i] = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic logic [N_CLK-1:0] f_highest(input logic [N_CLK-1:0] v);
      logic [N_CLK-1:0] r;
      r = '0;
      for (int i = 0; i < N_CLK; i++) begin
         if (v[i]) begin
            r    = '0;
            r[i] = 1'b1;
         end
      end
      return r;
   endfunction

   // Channels still to raise are always above every raised one, so the lowest pending bit is next.
   assign w_first_bit = f_lowest(i_mask);
   assign w_up_pend   = r_mask_l & ~r_en_out;
   assign w_up_bit    = f_lowest(w_up_pend);
   assign w_dn_bit    = f_highest(r_en_out);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_gap_l   <= '0;
         r_mask_l  <= '0;
         r_cnt     <= '0;
         r_en_out  <= '0;
         r_busy    <= 1'b0;
         r_running <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start && !i_stop) begin
                  r_gap_l  <= i_gap;
                  r_mask_l <= i_mask;
                  r_cnt    <= i_gap;
                  r_busy   <= 1'b1;
                  if (i_mask == '0) begin
                     r_state   <= S_RUN;
                     r_running <= 1'b1;
                  end else begin
                     r_state  <= S_UP;
                     r_en_out <= w_first_bit;
                  end
               end
            end
            S_UP, S_RUN: begin
               // A stop in UP is an abort: it takes priority over any pending rise.
               if (i_stop) begin
                  r_running <= 1'b0;
                  r_cnt     <= r_gap_l;
                  if (r_en_out == '0) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state  <= S_DOWN;
                     r_en_out <= r_en_out & ~w_dn_bit;
                  end
               end else if (r_state == S_UP) begin
                  if (r_cnt != '0) begin
                     r_cnt <= r_cnt - GAP_ONE;
                  end else if (w_up_pend != '0) begin
                     r_en_out <= r_en_out | w_up_bit;
                     r_cnt    <= r_gap_l;
                  end else begin
                     r_state   <= S_RUN;
                     r_running <= 1'b1;
                  end
               end
            end
            S_DOWN: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - GAP_ONE;
               end else if (r_en_out != '0) begin
                  r_en_out <= r_en_out & ~w_dn_bit;
                  r_cnt    <= r_gap_l;
               end else begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_en_out  = r_en_out;
   assign o_busy    = r_busy;
   assign o_running = r_running;
   assign o_done    = r_done;

endmodule

// File: tb/tb_clk_seq_ctrl.sv
// tb/tb_clk_seq_ctrl.sv - self-checking bench for clk_seq_ctrl against a timeline model
// The model schedules every rise/fall time with plain arithmetic when start/stop are accepted.
module tb_clk_seq_ctrl;
   localparam int N     = 4;
   localparam int GW    = 8;
   localparam int NEVER = 32'h3fffffff;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic [GW-1:0] gap = '0;
   logic [N-1:0]  mask = '0;
   logic [N-1:0]  en_out;
   logic          busy;
   logic          running;
   logic          done;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   bit m_act = 0;
   bit m_stopped = 0;
   int m_gap = 0;
   int m_stop_t = 0;
   int m_done_t = NEVER;
   int m_run_t = NEVER;
   int m_rise[N];
   int m_fall[N];

   logic [N-1:0] h_en[64];
   logic         h_run[64];
   logic         h_busy[64];
   logic         h_done[64];

   always #5 clk = ~clk;

   clk_seq_ctrl #(.N_CLK(N), .GAP_W(GW)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_start   (start),
      .i_stop    (stop),
      .i_gap     (gap),
      .i_mask    (mask),
      .o_en_out  (en_out),
      .o_busy    (busy),
      .o_running (running),
      .o_done    (done)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
      end
   endtask

   // Inputs present during cycle c are sampled by the edge that opens cycle c+1.
   task automatic model_apply(input int c);
      bit idle;
      int k;
      idle = !m_act || (m_stopped && c >= m_done_t);
      if (idle) begin
         if (start && !stop) begin
            m_act = 1; m_stopped = 0; m_gap = int'(gap); k = 0;
            for (int i = 0; i < N; i++) begin
               if (mask[i]) begin
                  m_rise[i] = c + 1 + k * (m_gap + 1);
                  k++;
               end else begin
                  m_rise[i] = NEVER;
               end
               m_fall[i] = NEVER;
            end
            m_run_t  = c + 1 + k * (m_gap + 1);
            m_done_t = NEVER;
         end
      end else if (!m_stopped && stop) begin
         m_stopped = 1; m_stop_t = c; k = 0;
         for (int i = N - 1; i >= 0; i--) begin
            if (m_rise[i] <= c) begin
               m_fall[i] = c + 1 + k * (m_gap + 1);
               k++;
            end else begin
               m_rise[i] = NEVER;
            end
         end
         m_done_t = c + 1 + k * (m_gap + 1);
      end
   endtask

   task automatic compare();
      logic [N-1:0] e_en;
      logic e_run, e_busy, e_done;
      for (int i = 0; i < N; i++)
         e_en[i] = m_act && m_rise[i] <= cyc && m_fall[i] > cyc;
      e_run  = m_act && cyc >= m_run_t && !(m_stopped && cyc > m_stop_t);
      e_busy = m_act && !(m_stopped && cyc >= m_done_t);
      e_done = m_act && m_stopped && cyc == m_done_t;
      chk("en_out", int'(en_out), int'(e_en));
      chk("running", int'(running), int'(e_run));
      chk("busy", int'(busy), int'(e_busy));
      chk("done", int'(done), int'(e_done));
   endtask

   task automatic tick();
      model_apply(cyc);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      compare();
   endtask

   task automatic do_reset();
      start = 1'b0; stop = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_en_out", int'(en_out), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_running", int'(running), 0);
      chk("rst_done", int'(done), 0);
      m_act = 0;
      @(posedge clk); cyc++;
      @(posedge clk); cyc++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // start at rel 0, held through rel hold; stop pulsed at rel stop_at; gap/mask disturbed after rel 0.
   task automatic run_dir(input int g, input logic [N-1:0] m, input int stop_at, input int hold, input int len);
      for (int r = 0; r < len; r++) begin
         h_en[r] = en_out; h_run[r] = running; h_busy[r] = busy; h_done[r] = done;
         start = (r <= hold);
         stop  = (r == stop_at);
         gap   = (r == 0) ? GW'(g) : GW'(7);
         mask  = (r == 0) ? m : ~m;
         tick();
      end
      start = 1'b0; stop = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         m_rise[i] = NEVER;
         m_fall[i] = NEVER;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("init_en_out", int'(en_out), 0);
      chk("init_busy", int'(busy), 0);
      chk("init_done", int'(done), 0);
      rst_n = 1'b1;
      cyc = 0;

      run_dir(2, 4'hF, 99, 0, 5);
      chk("midup_en4", int'(h_en[4]), 3);
      do_reset();

      run_dir(2, 4'hF, 20, 12, 36);
      chk("s1_busy0", int'(h_busy[0]), 0);
      chk("s1_en1", int'(h_en[1]), 1);
      chk("s1_busy1", int'(h_busy[1]), 1);
      chk("s1_en3", int'(h_en[3]), 1);
      chk("s1_en4", int'(h_en[4]), 3);
      chk("s1_en7", int'(h_en[7]), 7);
      chk("s1_en10", int'(h_en[10]), 15);
      chk("s1_run12", int'(h_run[12]), 0);
      chk("s1_run13", int'(h_run[13]), 1);
      chk("s1_en21", int'(h_en[21]), 7);
      chk("s1_run21", int'(h_run[21]), 0);
      chk("s1_en24", int'(h_en[24]), 3);
      chk("s1_en30", int'(h_en[30]), 0);
      chk("s1_done32", int'(h_done[32]), 0);
      chk("s1_busy32", int'(h_busy[32]), 1);
      chk("s1_done33", int'(h_done[33]), 1);
      chk("s1_busy33", int'(h_busy[33]), 0);
      do_reset();

      run_dir(0, 4'hA, 6, 0, 12);
      chk("s2_en1", int'(h_en[1]), 2);
      chk("s2_en2", int'(h_en[2]), 10);
      chk("s2_run2", int'(h_run[2]), 0);
      chk("s2_run3", int'(h_run[3]), 1);
      chk("s2_en7", int'(h_en[7]), 2);
      chk("s2_en8", int'(h_en[8]), 0);
      chk("s2_done9", int'(h_done[9]), 1);
      do_reset();

      run_dir(3, 4'hF, 6, 0, 18);
      chk("s3_en1", int'(h_en[1]), 1);
      chk("s3_en5", int'(h_en[5]), 3);
      chk("s3_en6", int'(h_en[6]), 3);
      chk("s3_en7", int'(h_en[7]), 1);
      chk("s3_en9", int'(h_en[9]), 1);
      chk("s3_en11", int'(h_en[11]), 0);
      chk("s3_done14", int'(h_done[14]), 0);
      chk("s3_done15", int'(h_done[15]), 1);
      do_reset();

      run_dir(2, 4'h0, 5, 0, 9);
      chk("s4_run1", int'(h_run[1]), 1);
      chk("s4_en1", int'(h_en[1]), 0);
      chk("s4_busy5", int'(h_busy[5]), 1);
      chk("s4_done6", int'(h_done[6]), 1);
      chk("s4_busy6", int'(h_busy[6]), 0);
      chk("s4_run6", int'(h_run[6]), 0);
      do_reset();

      run_dir(1, 4'hF, 0, 0, 4);
      chk("s5_busy1", int'(h_busy[1]), 0);
      chk("s5_en1", int'(h_en[1]), 0);
      chk("s5_en3", int'(h_en[3]), 0);

      for (int n = 0; n < 4000; n++) begin
         start = ($urandom_range(0, 7) == 0);
         stop  = ($urandom_range(0, 15) == 0);
         gap   = ($urandom_range(0, 15) == 0) ? GW'($urandom_range(0, 30)) : GW'($urandom_range(0, 3));
         mask  = N'($urandom);
         if ($urandom_range(0, 999) == 0) do_reset();
         else tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/clk_seq_ctrl.md
# clk_seq_ctrl

Synthesizable sequencer that drives the `enable` inputs of up to N_CLK clock generator instances. It brings them up in ascending index order and takes them down in descending order, with a programmable gap between steps. The gap lets each generator finish its phase delay or its current period before the next one changes. It sits between the system control logic (start/stop requests, configuration) and the bank of clock generators in the test/clocking subsystem.

## Interface
Parameters:
- N_CLK, 4, number of controlled generators (1..32)
- GAP_W, 8, width of gap counter/config

Ports:
- clk  in  1  sequencer clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  power-up request, sampled each cycle
- stop  in  1  power-down/abort request, sampled each cycle
- gap  in  GAP_W  idle cycles between steps; shadowed on accepted start
- mask  in  N_CLK  1 = channel participates; shadowed on accepted start
- en_out  out  N_CLK  registered enables to generators
- busy  out  1  high whenever state != IDLE
- running  out  1  high in RUN only
- done  out  1  one-cycle pulse on return to IDLE after power-down

## Operation
- States: IDLE, UP, RUN, DOWN.
- Shadow registers: gap_l and mask_l are loaded only when start is accepted in IDLE. Changes to gap or mask outside IDLE have no effect.
- IDLE:
  - en_out = 0.
  - start=1 with stop=0: latch shadows, go to UP.
  - start and stop both high: ignored.
  - stop alone: ignored.
- UP:
  - Walks indices 0..N_CLK-1. Masked-off channels are skipped at zero cost and stay 0.
  - Each unmasked channel's en_out bit sets, then gap_l idle cycles elapse before the next unmasked channel.
  - After the last unmasked channel sets, wait gap_l+1 cycles, then go to RUN.
  - mask_l = 0: go directly to RUN.
- RUN:
  - en_out holds.
  - start ignored.
  - stop goes to DOWN.
- DOWN:
  - Clears currently-set bits from the highest index downward, one per step, with gap_l idle cycles between clears.
  - After the last clear, wait gap_l+1 cycles, then go to IDLE with done asserted for that first IDLE cycle.
  - If no bits are set, go to IDLE on the next edge.
- stop during UP (abort):
  - Go to DOWN immediately and restart the gap counter.
  - The highest currently-set bit clears on the next edge.
  - A channel not yet enabled is never enabled.
- start during DOWN: ignored. No restart until IDLE is reached.
- Arithmetic:
  - Gap counter is GAP_W bits, loaded with gap_l and counting down to 0. No wrap.
  - gap=0 gives consecutive-cycle steps.
  - Maximum gap is 2^GAP_W-1.
  - Index register is clog2(N_CLK) bits, min 1.
- Reset (asserted asynchronously, any state):
  - en_out=0, busy=0, running=0, done=0.
  - State IDLE, shadows and counters cleared.
  - Release is synchronous to clk.

## Timing
- All outputs are registered. "At cycle t" means the value is visible after the rising edge t.
- start sampled at edge T (IDLE): first unmasked en_out bit is high at T+1.
- Successive unmasked rises occur gap_l+1 cycles apart.
- running rises gap_l+1 cycles after the last rise.
- busy rises at T+1.
- stop sampled at edge S (RUN or UP): highest set bit falls at S+1.
- Successive falls occur gap_l+1 cycles apart.
- done pulses, and busy falls, gap_l+1 cycles after the last fall.
- running falls at S+1.
- At most one en_out bit changes per cycle.
- No output glitches; en_out is driven straight from flops.

## Test plan
- N_CLK=4, gap=2, mask=1111, start at 0 -> en_out[0..3] rise at 1,4,7,10; running at 13. Then stop at 20 -> en_out[3..0] fall at 21,24,27,30; running low at 21; done pulse and busy low at 33.
- gap=0, mask=1010, start at 0 -> en_out[1] at 1, en_out[3] at 2, running at 3; en_out[0] and en_out[2] never rise.
- Abort: gap=3, mask=1111, start at 0 -> en_out[0] at 1, en_out[1] at 5. Then stop at 6 -> en_out[1] falls at 7, en_out[0] falls at 11, done at 15; en_out[2] and en_out[3] stay 0.
- mask=0000, start at 0 -> running at 1 with en_out=0. Then stop at 5 -> done at 6.
- Simultaneous/ignored: start+stop together in IDLE -> no change. start in RUN -> no change. gap changed to 7 in UP -> spacing stays 2.
- Reset mid-UP after en_out=0011 -> en_out=0, busy=0 immediately (asynchronous). After release, start at t -> en_out[0] rises at t+1.
